uart_tx_stream: RTL and testbench

- Transmit-side counterpart of the SoC UART receive path; streams a byte buffer out of data RAM on serial line `datao`.
- Format: 8N1, LSB first.
- Reads RAM words through the RAM's second (UART) port, splits each 32-bit word into bytes, and serialises them at a fixed bit period.
- Started by a one-cycle `start` pulse with a base word address and byte count; signals `done` when the last stop bit has finished.

---
 rtl/uart_tx_stream.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_stream.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_stream.sv
// Streams a byte buffer out of data RAM as 8N1 serial frames, LSB first.
// Reads 32-bit words through the RAM's UART port and splits them little-endian.
module uart_tx_stream #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [WIDTH-1:0] baseaddr,
  input  logic [WIDTH-1:0] bytecount,
  input  logic [WIDTH-1:0] rramdata,
  output logic [WIDTH-1:0] ramaddress,
  output logic             datao,
  output logic             busy,
  output logic             done
);

  localparam logic [15:0] BitLoad = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StStart,
    StData,
    StStop,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [2:0]       bitidx_q, bitidx_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             datao_q, datao_d;
  logic             done_q, done_d;
  logic             zero_req;
  logic [WIDTH-1:0] idx_next;

  assign idx_next = idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitidx_d = bitidx_q;
    idx_d    = idx_q;
    count_d  = count_q;
    base_d   = base_q;
    addr_d   = addr_q;
    shreg_d  = shreg_q;
    zero_req = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (bytecount != '0) begin
            base_d  = baseaddr;
            count_d = bytecount;
            idx_d   = '0;
            addr_d  = baseaddr;
            state_d = StFetch;
          end else begin
            zero_req = 1'b1;
          end
        end
      end
      StFetch: begin
        unique case (idx_q[1:0])
          2'd0:    shreg_d = rramdata[7:0];
          2'd1:    shreg_d = rramdata[15:8];
          2'd2:    shreg_d = rramdata[23:16];
          default: shreg_d = rramdata[31:24];
        endcase
        cnt_d   = BitLoad;
        state_d = StStart;
      end
      StStart: begin
        if (cnt_q == '0) begin
          cnt_d    = BitLoad;
          bitidx_d = '0;
          state_d  = StData;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          shreg_d  = {1'b0, shreg_q[7:1]};
          bitidx_d = bitidx_q + 3'd1;
          cnt_d    = BitLoad;
          if (bitidx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StStop: begin
        if (cnt_q == '0) begin
          idx_d = idx_next;
          if (idx_next == count_q) begin
            state_d = StDone;
          end else begin
            // Word address only advances when the byte index crosses a word boundary.
            addr_d  = base_q + (idx_next >> 2);
            state_d = StFetch;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Line is registered from the current state, so it lags the FSM by one cycle.
  always_comb begin
    datao_d = 1'b1;
    unique case (state_q)
      StStart: datao_d = 1'b0;
      StData:  datao_d = shreg_q[0];
      default: datao_d = 1'b1;
    endcase
    done_d = zero_req || (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bitidx_q <= '0;
      idx_q    <= '0;
      count_q  <= '0;
      base_q   <= '0;
      addr_q   <= '0;
      shreg_q  <= '0;
      datao_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitidx_q <= bitidx_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      base_q   <= base_d;
      addr_q   <= addr_d;
      shreg_q  <= shreg_d;
      datao_q  <= datao_d;
      done_q   <= done_d;
    end
  end

  assign ramaddress = addr_q;
  assign datao      = datao_q;
  assign done       = done_q;
  assign busy       = (state_q == StFetch) || (state_q == StStart) ||
                      (state_q == StData)  || (state_q == StStop);

endmodule

// File: tb/tb_uart_tx_stream.sv
// Scoreboard bench: stimulus pushes expected frames/done cycles, line and done
// monitors decode the DUT outputs and pop. Unit 0 uses 4 clocks/bit, unit 1 uses 1.
module tb_uart_tx_stream;

  localparam int C0 = 4;
  localparam int C1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        nrst0, start0, datao0, busy0, done0;
  logic [31:0] base0, count0, ram0, addr0;
  logic        nrst1, start1, datao1, busy1, done1;
  logic [31:0] base1, count1, ram1, addr1;

  logic [31:0] mem [0:255];
  assign ram0 = mem[addr0[7:0]];
  assign ram1 = mem[addr1[7:0]];

  uart_tx_stream #(.WIDTH(32), .CLKS_PER_BIT(C0)) dut (
    .clk(clk), .nrst(nrst0), .start(start0), .baseaddr(base0), .bytecount(count0),
    .rramdata(ram0), .ramaddress(addr0), .datao(datao0), .busy(busy0), .done(done0)
  );

  uart_tx_stream #(.WIDTH(32), .CLKS_PER_BIT(C1)) dut1 (
    .clk(clk), .nrst(nrst1), .start(start1), .baseaddr(base1), .bytecount(count1),
    .rramdata(ram1), .ramaddress(addr1), .datao(datao1), .busy(busy1), .done(done1)
  );

  typedef struct packed {
    int         t;
    logic [7:0] b;
  } fexp_t;

  fexp_t fq0[$];
  fexp_t fq1[$];
  int    dq0[$];
  int    dq1[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic logic get_line(input int u);
    return (u == 0) ? datao0 : datao1;
  endfunction

  function automatic logic get_nrst(input int u);
    return (u == 0) ? nrst0 : nrst1;
  endfunction

  function automatic logic get_done(input int u);
    return (u == 0) ? done0 : done1;
  endfunction

  function automatic void push_frame(input int u, input int t, input logic [7:0] b);
    fexp_t e;
    e.t = t;
    e.b = b;
    if (u == 0) fq0.push_back(e);
    else        fq1.push_back(e);
  endfunction

  function automatic void push_done(input int u, input int t);
    if (u == 0) dq0.push_back(t);
    else        dq1.push_back(t);
  endfunction

  function automatic bit pop_frame(input int u, output fexp_t e);
    e = '0;
    if (u == 0) begin
      if (fq0.size() == 0) return 1'b0;
      e = fq0.pop_front();
    end else begin
      if (fq1.size() == 0) return 1'b0;
      e = fq1.pop_front();
    end
    return 1'b1;
  endfunction

  function automatic bit pop_done(input int u, output int t);
    t = 0;
    if (u == 0) begin
      if (dq0.size() == 0) return 1'b0;
      t = dq0.pop_front();
    end else begin
      if (dq1.size() == 0) return 1'b0;
      t = dq1.pop_front();
    end
    return 1'b1;
  endfunction

  // Decodes frames by sampling mid-bit; a reset seen mid-frame discards it.
  task automatic mon_line(input int u);
    int    c;
    logic  prev;
    logic  cur;
    fexp_t e;
    bit    have;
    bit    aborted;
    int    fc;
    logic [7:0] got;
    logic [1:0] framing;
    logic  smp;
    c    = (u == 0) ? C0 : C1;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      cur = get_line(u);
      if (prev === 1'b1 && cur === 1'b0) begin
        fc      = cyc;
        have    = pop_frame(u, e);
        aborted = 1'b0;
        got     = '0;
        framing = '0;
        for (int i = 0; i < 10; i++) begin
          int w;
          w = (i == 0) ? c / 2 : c;
          for (int k = 0; k < w; k++) begin
            @(negedge clk);
            if (get_nrst(u) === 1'b0) aborted = 1'b1;
          end
          if (aborted) break;
          smp = get_line(u);
          if (i == 0)      framing[1] = smp;
          else if (i == 9) framing[0] = smp;
          else             got[i-1]   = smp;
        end
        if (!aborted) begin
          check($sformatf("u%0d frame expected", u), 64'(have), 64'd1);
          if (have) begin
            check($sformatf("u%0d frame start cycle", u), 64'(fc), 64'(e.t));
            check($sformatf("u%0d frame byte", u), 64'(got), 64'(e.b));
            check($sformatf("u%0d start/stop bits", u), 64'(framing), 64'b01);
          end
          prev = get_line(u);
        end else begin
          prev = 1'b0;
        end
      end else begin
        prev = cur;
      end
    end
  endtask

  task automatic mon_done(input int u);
    int t;
    bit have;
    forever begin
      @(negedge clk);
      if (get_done(u) === 1'b1) begin
        have = pop_done(u, t);
        check($sformatf("u%0d done expected", u), 64'(have), 64'd1);
        if (have) check($sformatf("u%0d done cycle", u), 64'(cyc), 64'(t));
      end
    end
  endtask

  initial mon_line(0);
  initial mon_line(1);
  initial mon_done(0);
  initial mon_done(1);

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(input int u, input logic [31:0] b, input logic [31:0] n, output int s);
    if (u == 0) begin
      start0 = 1'b1; base0 = b; count0 = n;
    end else begin
      start1 = 1'b1; base1 = b; count1 = n;
    end
    step(1);
    s = cyc;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  initial begin
    int s;
    logic bad;
    logic [7:0] bytes_a [4];
    logic [7:0] bytes_b [6];
    bytes_a = '{8'h11, 8'h22, 8'h33, 8'h44};
    bytes_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h6F, 8'h5E};

    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD0000 | i;
    mem[8'h10] = 32'h44332211;
    mem[8'h20] = 32'hA1B2C3D4;
    mem[8'h21] = 32'h99885E6F;

    nrst0 = 1'b0; start0 = 1'b0; base0 = '0; count0 = '0;
    nrst1 = 1'b0; start1 = 1'b0; base1 = '0; count1 = '0;
    step(2);
    nrst0 = 1'b1;
    nrst1 = 1'b1;

    // Idle after reset
    for (int i = 0; i < 50; i++) begin
      check("u0 idle outputs", 64'({datao0, busy0, done0, addr0}), {29'd0, 3'b100, 32'h0});
      step(1);
    end
    check("u1 idle outputs", 64'({datao1, busy1, done1, addr1}), {29'd0, 3'b100, 32'h0});

    // Four bytes from one word
    go(0, 32'h10, 32'd4, s);
    check("u0 busy after start", 64'(busy0), 64'd1);
    for (int j = 0; j < 4; j++) push_frame(0, s + 2 + j * 41, bytes_a[j]);
    push_done(0, s - 1 + 165);
    bad = 1'b0;
    for (int i = 0; i < 170; i++) begin
      if (addr0 !== 32'h10) bad = 1'b1;
      step(1);
    end
    check("u0 ramaddress held at 0x10", 64'(bad), 64'd0);
    check("u0 busy low after transfer", 64'(busy0), 64'd0);

    // Six bytes spanning two words
    go(0, 32'h20, 32'd6, s);
    for (int j = 0; j < 6; j++) push_frame(0, s + 2 + j * 41, bytes_b[j]);
    push_done(0, s + 6 * 41);
    step(163);
    check("u0 ramaddress before 5th fetch", 64'(addr0), 64'h20);
    step(1);
    check("u0 ramaddress at 5th fetch", 64'(addr0), 64'h21);
    step(90);

    // Zero-length request
    go(0, 32'h33, 32'd0, s);
    push_done(0, s);
    check("u0 busy on zero count", 64'(busy0), 64'd0);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (datao0 !== 1'b1 || busy0 !== 1'b0) bad = 1'b1;
      step(1);
    end
    check("u0 line idle on zero count", 64'(bad), 64'd0);

    // Start re-pulsed mid-byte is ignored
    go(0, 32'h10, 32'd2, s);
    push_frame(0, s + 2, 8'h11);
    push_frame(0, s + 43, 8'h22);
    push_done(0, s + 82);
    step(15);
    start0 = 1'b1; base0 = 32'h20; count0 = 32'd5;
    step(1);
    start0 = 1'b0;
    step(80);

    // Reset during a data bit, then a clean single byte
    go(0, 32'h10, 32'd2, s);
    push_frame(0, s + 2, 8'h11);
    step(9);
    nrst0 = 1'b0;
    step(1);
    check("u0 line/busy/done after reset", 64'({datao0, busy0, done0}), 64'b100);
    nrst0 = 1'b1;
    step(10);
    go(0, 32'h20, 32'd1, s);
    push_frame(0, s + 2, 8'hD4);
    push_done(0, s + 41);
    step(50);

    // Same at one clock per bit
    go(1, 32'h10, 32'd1, s);
    push_frame(1, s + 2, 8'h11);
    step(3);
    nrst1 = 1'b0;
    step(1);
    check("u1 line/busy/done after reset", 64'({datao1, busy1, done1}), 64'b100);
    nrst1 = 1'b1;
    step(5);
    go(1, 32'h20, 32'd1, s);
    push_frame(1, s + 2, 8'hD4);
    push_done(1, s + 11);
    step(20);

    check("u0 frames outstanding", 64'(fq0.size()), 64'd0);
    check("u1 frames outstanding", 64'(fq1.size()), 64'd0);
    check("u0 done outstanding", 64'(dq0.size()), 64'd0);
    check("u1 done outstanding", 64'(dq1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
